// File: rtl/pet_clk_reset_gen.sv
// pet_clk_reset_gen: PLL lock sequencer and phase-aligned pixel/CPU clock-enable generator.
// Optional PET_TURBO_EN adds a synchronised `turbo` input selecting an 8x faster CPU enable.
module pet_clk_reset_gen #(
    parameter int PIX_DIV  = 7,
    parameter int CPU_DIV  = 56,
    parameter int RST_HOLD = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
`ifdef PET_TURBO_EN
    input  logic turbo,
`endif
    output logic sys_reset,
    output logic ready,
    output logic ce_pix,
    output logic ce_cpu,
    output logic ce_cpu_n
);
    localparam int PW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
    localparam int CW = $clog2(CPU_DIV);
    localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);
    localparam logic [CW-1:0] CPU_LAST = CW'(CPU_DIV - 1);
    localparam logic [CW-1:0] CPU_MID = CW'(CPU_DIV / 2 - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    if (CPU_DIV % 2 != 0 || CPU_DIV < 2 * PIX_DIV || CPU_DIV % PIX_DIV != 0) begin : g_bad_cpu_div
        $error("pet_clk_reset_gen: CPU_DIV must be even, >= 2*PIX_DIV and a multiple of PIX_DIV");
    end

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

    state_t state, state_nx;
    logic lock_meta, locked_s, run_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [PW-1:0] pix_cnt, pix_nx;
    logic [CW-1:0] cpu_cnt, cpu_nx, cpu_last, cpu_last_nx, cpu_mid_nx;

`ifdef PET_TURBO_EN
    localparam int TURBO_DIV = CPU_DIV / 8;
    if (TURBO_DIV < PIX_DIV || TURBO_DIV % PIX_DIV != 0) begin : g_bad_turbo_div
        $error("pet_clk_reset_gen: CPU_DIV/8 must be a multiple of PIX_DIV");
    end
    logic turbo_meta, turbo_s, turbo_mode, turbo_mode_nx;
    // Mode only changes at a CPU cycle boundary so no cycle is stretched or cut short.
    assign turbo_mode_nx = (ce_cpu || state != RUN) ? turbo_s : turbo_mode;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            {turbo_meta, turbo_s, turbo_mode} <= '0;
        else
            {turbo_meta, turbo_s, turbo_mode} <= {turbo, turbo_meta, turbo_mode_nx};
    assign cpu_last    = turbo_mode ? CW'(TURBO_DIV - 1) : CPU_LAST;
    assign cpu_last_nx = turbo_mode_nx ? CW'(TURBO_DIV - 1) : CPU_LAST;
    assign cpu_mid_nx  = turbo_mode_nx ? CW'(TURBO_DIV / 2 - 1) : CPU_MID;
`else
    assign cpu_last    = CPU_LAST;
    assign cpu_last_nx = CPU_LAST;
    assign cpu_mid_nx  = CPU_MID;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {lock_meta, locked_s} <= '0;
            state <= WAIT_LOCK;
            hold_cnt <= '0;
        end else begin
            {lock_meta, locked_s} <= {pll_locked, lock_meta};
            state <= state_nx;
            hold_cnt <= hold_nx;
        end

    always_comb begin
        state_nx = state;
        if (!locked_s)
            state_nx = WAIT_LOCK;
        else if (state == WAIT_LOCK)
            state_nx = HOLD;
        else if (state == HOLD && hold_cnt == HOLD_LAST)
            state_nx = RUN;
    end

    // Enables are decoded from next-cycle values so each pulse lines up with its counter's last count.
    always_comb begin
        run_nx  = state_nx == RUN;
        hold_nx = state == HOLD ? hold_cnt + 1'b1 : '0;
        pix_nx  = (state == RUN && run_nx && pix_cnt != PIX_LAST) ? pix_cnt + 1'b1 : '0;
        cpu_nx  = (state == RUN && run_nx && cpu_cnt != cpu_last) ? cpu_cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pix_cnt   <= '0;
            cpu_cnt   <= '0;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            ce_pix    <= 1'b0;
            ce_cpu    <= 1'b0;
            ce_cpu_n  <= 1'b0;
        end else begin
            pix_cnt   <= pix_nx;
            cpu_cnt   <= cpu_nx;
            sys_reset <= !run_nx;
            ready     <= run_nx;
            ce_pix    <= run_nx && pix_nx == PIX_LAST;
            ce_cpu    <= run_nx && cpu_nx == cpu_last_nx;
            ce_cpu_n  <= run_nx && cpu_nx == cpu_mid_nx;
        end
endmodule

// File: tb/tb_pet_clk_reset_gen.sv
// tb_pet_clk_reset_gen: randomized lock/reset stimulus against a streak-and-modulo reference model.
module tb_pet_clk_reset_gen;
    localparam int PIX_DIV  = 7;
    localparam int CPU_DIV  = 56;
    localparam int RST_HOLD = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b0;
`ifdef PET_TURBO_EN
    logic turbo = 1'b0;
`endif
    logic sys_reset, ready, ce_pix, ce_cpu, ce_cpu_n;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    pet_clk_reset_gen #(.PIX_DIV(PIX_DIV), .CPU_DIV(CPU_DIV), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_locked(pll_locked),
`ifdef PET_TURBO_EN
        .turbo(turbo),
`endif
        .sys_reset(sys_reset),
        .ready(ready),
        .ce_pix(ce_pix),
        .ce_cpu(ce_cpu),
        .ce_cpu_n(ce_cpu_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: RUN after edge n iff lock was sampled high on RST_HOLD+1 consecutive edges ending at n-2;
    // enables follow from the RUN cycle index by modulo arithmetic.
    int s0 = 0, s1 = 0, s2 = 0, run_len = 0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s0 = 0; s1 = 0; s2 = 0; run_len = 0;
        end else begin
            s2 = s1;
            s1 = s0;
            s0 = pll_locked ? s0 + 1 : 0;
            run_len = (s2 >= RST_HOLD + 1) ? run_len + 1 : 0;
        end

    always @(negedge clk) begin
        check("sys_reset", sys_reset, run_len == 0);
        check("ready", ready, run_len > 0);
        check("ce_pix", ce_pix, run_len > 0 && run_len % PIX_DIV == 0);
        check("ce_cpu", ce_cpu, run_len > 0 && run_len % CPU_DIV == 0);
        check("ce_cpu_n", ce_cpu_n, run_len > 0 && run_len % CPU_DIV == CPU_DIV / 2);
    end

    task automatic time_to_run(output int n);
        n = 0;
        while (sys_reset !== 1'b0 && n < 3 * RST_HOLD) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic first_cpu(output int n);
        n = 1;
        while (ce_cpu !== 1'b1 && n < 4 * CPU_DIV) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int base, n, lat, np, nc, nn, bad;
        repeat (3) @(negedge clk);
        check("reset_sys_reset", sys_reset, 1);
        check("reset_ready", ready, 0);
        rst_n = 1'b1;
        base = cyc;
        while (cyc - base < 9) @(negedge clk);
        pll_locked = 1'b1;
        for (int i = 0; i < 2 * RST_HOLD && sys_reset !== 1'b0; i++) @(negedge clk);
        check("powerup_release_edge", cyc - base, 12 + RST_HOLD);

        np = 0; nc = 0; nn = 0; bad = 0;
        for (int i = 0; i < 10 * CPU_DIV; i++) begin
            np += int'(ce_pix);
            nc += int'(ce_cpu);
            nn += int'(ce_cpu_n);
            bad += int'(ce_cpu && !ce_pix);
            @(negedge clk);
        end
        check("steady_ce_pix_count", np, 80);
        check("steady_ce_cpu_count", nc, 10);
        check("steady_ce_cpu_n_count", nn, 10);
        check("steady_cpu_without_pix", bad, 0);

        pll_locked = 1'b0;
        lat = -1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (sys_reset === 1'b1 && lat < 0) lat = i - 1;
        end
        check("lock_loss_latency", lat, 2);
        pll_locked = 1'b1;
        time_to_run(n);
        check("relock_hold_run", n, RST_HOLD + 3);
        first_cpu(n);
        check("relock_first_ce_cpu", n, CPU_DIV);

        pll_locked = 1'b0;
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        repeat (503) @(negedge clk);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_abort_still_reset", sys_reset, 1);
        pll_locked = 1'b1;
        time_to_run(n);
        check("hold_abort_fresh_hold", n, RST_HOLD + 3);

        for (int i = 0; i < 4 * PIX_DIV && ce_pix !== 1'b1; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sys_reset", sys_reset, 1);
        check("async_rst_ready", ready, 0);
        check("async_rst_ce_pix", ce_pix, 0);
        check("async_rst_ce_cpu", {ce_cpu, ce_cpu_n}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        time_to_run(n);
        check("post_reset_run", n, RST_HOLD + 3);
        first_cpu(n);
        check("post_reset_first_ce_cpu", n, CPU_DIV);

        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(20, 1300)) @(negedge clk);
            pll_locked = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            pll_locked = 1'b1;
        end
        time_to_run(n);
        check("random_final_run", n, RST_HOLD + 3);
        repeat (3 * CPU_DIV) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
